inst_encoder_loader: RTL and testbench
======================================

// Module: inst_encoder_loader
// PURPOSE
//  Inverse of the instruction decoder. Accepts decoded SIMPLE instruction fields over a
//  valid/ready port and encodes each into a 16-bit SIMPLE word. Buffers words in a FIFO and
//  writes them sequentially into instruction memory; loading ends when HLT has been written.
//  Used as the program loader in front of the pipeline's instruction memory.
// PARAMETERS
//  ADDR_W     8   imem address width
//  BASE_ADDR  0   first imem address written after start
//  DEPTH      4   FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       pulse: begin or restart a load
//  fld_valid    in   1       field bundle valid
//  fld_ready    out  1       bundle accepted when fld_valid & fld_ready at clk edge
//  fld_class    in   2       inst[15:14]: 00 LD, 01 ST, 10 LI/B/BR, 11 ALU/shift/IO/HLT
//  fld_op       in   4       class11: op3 -> [7:4]; class10: op2 in [2:0] -> [13:11]
//  fld_ra       in   3       [13:11] (classes 00/01/11)
//  fld_rb       in   3       [10:8] (LI dest / branch cond / Rd)
//  fld_imm      in   8       displacement/immediate
//  imem_we      out  1       write request, held until imem_ready
//  imem_ready   in   1       write completes on edge where imem_we & imem_ready
//  imem_addr    out  ADDR_W  write address
//  imem_wdata   out  16      encoded word
//  busy         out  1       state == LOAD
//  done         out  1       HLT written; held until start
//  err          out  1       load aborted; held until start
//  err_code     out  2       01 illegal fields, 10 address overflow
//  word_cnt     out  ADDR_W+1  words written this load
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FIFO empty; addr = BASE_ADDR.
//  FSM: IDLE -start-> LOAD; LOAD -HLT write completes-> DONE; LOAD -error-> ERR.
//   start in any state (including LOAD): flush FIFO, addr=BASE_ADDR, word_cnt=0,
//   clear done/err/err_code, drop any pending imem_we, enter LOAD next cycle.
//   fld_ready is 0 in the cycle start is high.
//  fld_ready = (state==LOAD) & !fifo_full & !halt_accepted & !start.
//  Encoding (registered into FIFO on accept edge; entry = {is_hlt, word}):
//   class00/01: {cls, ra, rb, imm[7:0]}
//   class10: op[2:0] must be 000 (LI), 100 (B) or 111 (Bcond); else illegal.
//     {2'b10, op[2:0], rb, imm}, except rb field forced to 000 for B.
//   class11: op 0111 and 1110 are illegal. {2'b11, ra, rb, op, low}; low = imm[3:0] for
//     op 1000..1011 (shifts), else 4'b0000. is_hlt = (op==1111).
//   Illegal bundle: not enqueued; state -> ERR, err_code=01; queued words are discarded.
//  After HLT accepted, fld_ready stays 0 until start.
//  Writer: when LOAD and !imem_we and FIFO non-empty, pop head and register imem_we=1,
//   imem_addr=addr, imem_wdata=word. Accept at edge N -> imem_we high at N+2 (empty FIFO).
//   On completion: addr+1, word_cnt+1, imem_we=0 (one idle cycle minimum between writes).
//   imem_addr/imem_wdata stable while imem_we=1 and imem_ready=0.
//  Overflow: completed write at addr = 2^ADDR_W-1 of a non-HLT word -> ERR, err_code=10.
//   Completed HLT write at the max address -> DONE (no error).
//  FIFO simultaneous push/pop when full: push blocked by fld_ready, pop proceeds.
//  Async reset mid-load: immediate return to reset state; partial program left in imem.
// TESTING
//  1 start; LI rb=1 imm=05 (cls10 op0000) -> imem_wdata=16'h8105 addr 0, we 2 cycles post-accept.
//  2 ADD ra=2 rb=3 imm=FF (cls11 op0000), then HLT -> D300 @0, C0F0 @1; done=1, word_cnt=2.
//  3 SLL ra=0 rb=1 op1000 imm=03 -> C183; B imm=FE rb=5 -> A0FE (rb forced 0).
//  4 imem_ready low 8 cycles, DEPTH=4, 6 bundles -> fld_ready low after 4 queued; all 6 in order.
//  5 cls10 op0010 -> err=1, err_code=01, no imem_we; start -> LOAD, err cleared.
//  6 ADDR_W=2, 5 non-HLT words -> 4 writes at 0..3, then err_code=10; rst_n low mid-load -> all 0.

Source files
------------

// File: rtl/inst_encoder_loader.sv
// Program loader: encodes decoded SIMPLE instruction fields into 16-bit words, queues them
// in a small FIFO and writes them one by one into instruction memory until HLT lands.
module inst_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fld_valid,
  output logic              fld_ready,
  input  logic [1:0]        fld_class,
  input  logic [3:0]        fld_op,
  input  logic [2:0]        fld_ra,
  input  logic [2:0]        fld_rb,
  input  logic [7:0]        fld_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_cnt,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  state_t             r_state, w_state_nxt;
  logic [16:0]        r_fifo [DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [PTR_W:0]     r_count;
  logic               r_halt_acc;
  logic               r_we;
  logic               r_wr_hlt;
  logic [ADDR_W-1:0]  r_addr, r_wr_addr;
  logic [15:0]        r_wdata;
  logic [ADDR_W:0]    r_cnt;
  logic [1:0]         r_err_code;

  logic [15:0]        w_word;
  logic               w_legal, w_is_hlt;
  logic               w_accept, w_push, w_pop, w_wr_done, w_enter_err;

  // Handshakes: a bundle (or an imem write) transfers on the rising edge where valid/we and
  // ready are both high; the offering side holds its payload stable until that edge.
  assign fld_ready = (r_state == S_LOAD) & (r_count != FULL_CNT) & ~r_halt_acc & ~start;
  assign w_accept  = fld_valid & fld_ready;
  assign w_push    = w_accept & w_legal;
  assign w_pop     = (r_state == S_LOAD) & ~r_we & (r_count != '0);
  assign w_wr_done = r_we & imem_ready;

  always_comb begin
    w_word   = {fld_class, fld_ra, fld_rb, fld_imm};
    w_legal  = 1'b1;
    w_is_hlt = 1'b0;
    case (fld_class)
      2'b10: begin
        w_legal = (fld_op[2:0] == 3'b000) || (fld_op[2:0] == 3'b100) || (fld_op[2:0] == 3'b111);
        // Unconditional branch carries no condition register
        w_word  = {2'b10, fld_op[2:0], (fld_op[2:0] == 3'b100) ? 3'b000 : fld_rb, fld_imm};
      end
      2'b11: begin
        w_legal  = (fld_op != 4'b0111) && (fld_op != 4'b1110);
        w_is_hlt = (fld_op == 4'b1111);
        w_word   = {2'b11, fld_ra, fld_rb, fld_op,
                    (fld_op[3:2] == 2'b10) ? fld_imm[3:0] : 4'b0000};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enter_err = 1'b0;
    if (start) begin
      w_state_nxt = S_LOAD;
    end else if (r_state == S_LOAD) begin
      if (w_accept && !w_legal) begin
        w_state_nxt = S_ERR;
        w_enter_err = 1'b1;
      end else if (w_wr_done && r_wr_hlt) begin
        w_state_nxt = S_DONE;
      end else if (w_wr_done && (r_wr_addr == '1)) begin
        w_state_nxt = S_ERR;
        w_enter_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= {w_is_hlt, w_word};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_halt_acc <= 1'b0;
      r_we       <= 1'b0;
      r_wr_hlt   <= 1'b0;
      r_addr     <= ADDR_W'(BASE_ADDR);
      r_wr_addr  <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_err_code <= 2'b00;
    end else if (start) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_halt_acc <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= ADDR_W'(BASE_ADDR);
      r_cnt      <= '0;
      r_err_code <= 2'b00;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        if (w_is_hlt) r_halt_acc <= 1'b1;
      end
      if (w_pop) begin
        {r_wr_hlt, r_wdata} <= r_fifo[r_rptr];
        r_wr_addr <= r_addr;
        r_we      <= 1'b1;
        r_rptr    <= r_rptr + 1'b1;
      end
      r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
      if (w_wr_done) begin
        r_we   <= 1'b0;
        r_addr <= r_addr + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
      // Abort: discard everything still queued and any write not yet completed
      if (w_enter_err) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_we       <= 1'b0;
        r_err_code <= (w_accept && !w_legal) ? 2'b01 : 2'b10;
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_wr_addr;
  assign imem_wdata = r_wdata;
  assign busy       = (r_state == S_LOAD);
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_ERR);
  assign err_code   = r_err_code;
  assign word_cnt   = r_cnt;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: vector table, hand-written corner sequences and random
// programs checked against a field-level encoding model and an expected-write queue.
module tb_inst_encoder_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, fld_valid = 1'b0, imem_ready = 1'b1;
  logic [1:0] fld_class = 2'd0;
  logic [3:0] fld_op = 4'd0;
  logic [2:0] fld_ra = 3'd0, fld_rb = 3'd0;
  logic [7:0] fld_imm = 8'd0;

  logic        fld_ready, imem_we, busy, done, err;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [1:0]  err_code, dbg_state;
  logic [8:0]  word_cnt;

  logic        ovf_ready, ovf_we, ovf_busy, ovf_done, ovf_err;
  logic [1:0]  ovf_addr, ovf_code, ovf_dbg;
  logic [15:0] ovf_wdata;
  logic [2:0]  ovf_cnt;

  inst_encoder_loader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fld_valid(fld_valid), .fld_ready(fld_ready),
    .fld_class(fld_class), .fld_op(fld_op), .fld_ra(fld_ra), .fld_rb(fld_rb), .fld_imm(fld_imm),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .word_cnt(word_cnt),
    .dbg_state(dbg_state)
  );

  inst_encoder_loader #(.ADDR_W(2)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(start), .fld_valid(fld_valid), .fld_ready(ovf_ready),
    .fld_class(fld_class), .fld_op(fld_op), .fld_ra(fld_ra), .fld_rb(fld_rb), .fld_imm(fld_imm),
    .imem_we(ovf_we), .imem_ready(imem_ready), .imem_addr(ovf_addr), .imem_wdata(ovf_wdata),
    .busy(ovf_busy), .done(ovf_done), .err(ovf_err), .err_code(ovf_code), .word_cnt(ovf_cnt),
    .dbg_state(ovf_dbg)
  );

  typedef struct {
    logic [1:0] cls; logic [3:0] op; logic [2:0] ra; logic [2:0] rb; logic [7:0] imm;
    bit legal; logic [15:0] word;
  } vec_t;

  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  int  n_checks = 0, n_fail = 0;
  bit  rand_ready = 1'b0;
  bit  ovf_chk = 1'b0;
  int  ovf_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Encoding reference built from the field rules with plain arithmetic
  function automatic void model(input logic [1:0] c, input logic [3:0] op, input logic [2:0] ra,
                                input logic [2:0] rb, input logic [7:0] imm,
                                output bit legal, output bit hlt, output logic [15:0] w);
    int o, r;
    legal = 1'b1;
    hlt   = 1'b0;
    if (c < 2) begin
      w = 16'(int'(c) * 16384 + int'(ra) * 2048 + int'(rb) * 256 + int'(imm));
    end else if (c == 2) begin
      o = int'(op) % 8;
      legal = (o == 0) || (o == 4) || (o == 7);
      r = (o == 4) ? 0 : int'(rb);
      w = 16'(2 * 16384 + o * 2048 + r * 256 + int'(imm));
    end else begin
      legal = !(op == 7 || op == 14);
      hlt = (op == 15);
      r = (op >= 8 && op <= 11) ? int'(imm) % 16 : 0;
      w = 16'(3 * 16384 + int'(ra) * 2048 + int'(rb) * 256 + int'(op) * 16 + r);
    end
  endfunction

  // Scoreboard: every completed imem write must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n && !start && imem_we && imem_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("imem_write", {8'h0, imem_addr, imem_wdata}, {8'h0, mon_e});
      end
    end
    if (ovf_chk && rst_n && !start && ovf_we && imem_ready) begin
      check("ovf_write_addr", {30'b0, ovf_addr}, ovf_n);
      ovf_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) imem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] c, input logic [3:0] op, input logic [2:0] ra,
                      input logic [2:0] rb, input logic [7:0] imm);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    fld_class = c; fld_op = op; fld_ra = ra; fld_rb = rb; fld_imm = imm;
    fld_valid = 1'b1;
    while (!acc && n < 200) begin
      #1;
      acc = fld_ready;
      tick();
      n++;
    end
    fld_valid = 1'b0;
    check("send_accepted", 32'(acc), 1);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || err) && n < 500) begin
      tick();
      n++;
    end
    check("load_finished", 32'(done || err), 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    logic [15:0] w;
    logic [1:0] c;
    logic [3:0] op;
    logic [2:0] ra, rb;
    logic [7:0] imm;
    bit lg, hl;
    int a, n, k;

    tbl[0]  = '{2'd0, 4'h0, 3'd1, 3'd2, 8'h34, 1'b1, 16'h0A34};
    tbl[1]  = '{2'd1, 4'h0, 3'd7, 3'd0, 8'h80, 1'b1, 16'h7880};
    tbl[2]  = '{2'd2, 4'h0, 3'd0, 3'd1, 8'h05, 1'b1, 16'h8105};
    tbl[3]  = '{2'd2, 4'h4, 3'd0, 3'd5, 8'hFE, 1'b1, 16'hA0FE};
    tbl[4]  = '{2'd2, 4'h7, 3'd0, 3'd3, 8'h10, 1'b1, 16'hBB10};
    tbl[5]  = '{2'd3, 4'h8, 3'd0, 3'd1, 8'h03, 1'b1, 16'hC183};
    tbl[6]  = '{2'd3, 4'hB, 3'd5, 3'd6, 8'hAB, 1'b1, 16'hEEBB};
    tbl[7]  = '{2'd3, 4'h0, 3'd2, 3'd3, 8'hFF, 1'b1, 16'hD300};
    tbl[8]  = '{2'd3, 4'hC, 3'd1, 3'd1, 8'hFF, 1'b1, 16'hC9C0};
    tbl[9]  = '{2'd3, 4'h6, 3'd4, 3'd2, 8'h0F, 1'b1, 16'hE260};
    tbl[10] = '{2'd3, 4'hF, 3'd3, 3'd4, 8'hFF, 1'b1, 16'hDCF0};
    tbl[11] = '{2'd2, 4'h2, 3'd0, 3'd0, 8'h00, 1'b0, 16'h0000};
    tbl[12] = '{2'd2, 4'h1, 3'd1, 3'd1, 8'h11, 1'b0, 16'h0000};
    tbl[13] = '{2'd2, 4'h5, 3'd0, 3'd0, 8'h00, 1'b0, 16'h0000};
    tbl[14] = '{2'd3, 4'h7, 3'd1, 3'd2, 8'h03, 1'b0, 16'h0000};
    tbl[15] = '{2'd3, 4'hE, 3'd0, 3'd0, 8'h00, 1'b0, 16'h0000};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {fld_ready, imem_we, busy, done, err, err_code, word_cnt}, 0);
    check("reset_imem_bus", {imem_addr, imem_wdata}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // LI: write appears two edges after the accept edge
    do_start();
    check("t1_busy", 32'(busy), 1);
    exp_q.push_back({8'd0, 16'h8105});
    fld_class = 2'd2; fld_op = 4'h0; fld_ra = 3'd0; fld_rb = 3'd1; fld_imm = 8'h05;
    fld_valid = 1'b1;
    #1 check("t1_ready", 32'(fld_ready), 1);
    @(posedge clk);
    #1 fld_valid = 1'b0;
    @(negedge clk) check("t1_we_after_accept", 32'(imem_we), 0);
    @(negedge clk) check("t1_we_two_cycles", 32'(imem_we), 1);
    tick();
    exp_q.push_back({8'd1, 16'hC0F0});
    send(2'd3, 4'hF, 3'd0, 3'd0, 8'h00);
    check("t1_ready_after_hlt", 32'(fld_ready), 0);
    wait_end();
    check("t1_done", {done, err, word_cnt}, {2'b10, 9'd2});

    // ADD then HLT
    do_start();
    check("t2_start_clears", {done, busy, word_cnt}, {2'b01, 9'd0});
    exp_q.push_back({8'd0, 16'hD300});
    exp_q.push_back({8'd1, 16'hC0F0});
    send(2'd3, 4'h0, 3'd2, 3'd3, 8'hFF);
    send(2'd3, 4'hF, 3'd0, 3'd0, 8'h00);
    wait_end();
    check("t2_done", {done, err, busy, word_cnt}, {3'b100, 9'd2});
    check("t2_queue_empty", exp_q.size(), 0);

    // Table program: every legal vector in order, HLT last
    do_start();
    a = 0;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].legal) begin
        exp_q.push_back({8'(a), tbl[i].word});
        a++;
        send(tbl[i].cls, tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].imm);
      end
    end
    wait_end();
    check("tbl_done", {done, word_cnt}, {1'b1, 9'd11});
    check("tbl_queue_empty", exp_q.size(), 0);

    // Illegal bundles abort with code 01 and nothing is written
    for (int i = 0; i < 16; i++) begin
      if (!tbl[i].legal) begin
        do_start();
        send(tbl[i].cls, tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].imm);
        check("illegal_err", {err, err_code, busy, fld_ready, imem_we}, {1'b1, 2'b01, 3'b000});
      end
    end
    do_start();
    check("restart_clears_err", {err, err_code, busy}, {3'b000, 1'b1});

    // Illegal bundle behind queued words discards them and the pending write
    imem_ready = 1'b0;
    send(2'd0, 4'h0, 3'd1, 3'd1, 8'h11);
    send(2'd1, 4'h0, 3'd2, 3'd2, 8'h22);
    check("t5_pending_we", 32'(imem_we), 1);
    send(2'd3, 4'hE, 3'd0, 3'd0, 8'h00);
    check("t5_abort", {err, err_code, imem_we}, {1'b1, 2'b01, 1'b0});
    imem_ready = 1'b1;
    repeat (5) tick();
    check("t5_err_held", {err, word_cnt}, {1'b1, 9'd0});

    // Backpressure: one word held in the writer, four in the FIFO, then full
    do_start();
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      model(2'd0, 4'h0, 3'(i), 3'(i), 8'(i * 17), lg, hl, w);
      exp_q.push_back({8'(i), w});
      send(2'd0, 4'h0, 3'(i), 3'(i), 8'(i * 17));
      if (i == 3) check("t4_not_full_yet", 32'(fld_ready), 1);
    end
    check("t4_full", 32'(fld_ready), 0);
    fld_class = 2'd1; fld_op = 4'h0; fld_ra = 3'd6; fld_rb = 3'd5; fld_imm = 8'h99;
    fld_valid = 1'b1;
    repeat (3) tick();
    check("t4_still_full", 32'(fld_ready), 0);
    check("t4_hold", {imem_we, imem_addr, imem_wdata}, {1'b1, 8'd0, 16'h0000});
    fld_valid = 1'b0;
    imem_ready = 1'b1;
    exp_q.push_back({8'd5, 16'h7599});
    send(2'd1, 4'h0, 3'd6, 3'd5, 8'h99);
    exp_q.push_back({8'd6, 16'hC0F0});
    send(2'd3, 4'hF, 3'd0, 3'd0, 8'h00);
    wait_end();
    check("t4_done", {done, word_cnt}, {1'b1, 9'd7});
    check("t4_queue_empty", exp_q.size(), 0);

    // Random programs with random imem backpressure
    rand_ready = 1'b1;
    for (int it = 0; it < 20; it++) begin
      do_start();
      n = $urandom_range(1, 8);
      for (k = 0; k < n; k++) begin
        do begin
          c = 2'($urandom_range(0, 3)); op = 4'($urandom_range(0, 15));
          ra = 3'($urandom_range(0, 7)); rb = 3'($urandom_range(0, 7));
          imm = 8'($urandom_range(0, 255));
          model(c, op, ra, rb, imm, lg, hl, w);
        end while (!lg || hl);
        exp_q.push_back({8'(k), w});
        send(c, op, ra, rb, imm);
      end
      model(2'd3, 4'hF, 3'd7, 3'd7, 8'hFF, lg, hl, w);
      exp_q.push_back({8'(n), w});
      send(2'd3, 4'hF, 3'd7, 3'd7, 8'hFF);
      wait_end();
      check("rand_done", {done, err, word_cnt}, {2'b10, 9'(n + 1)});
      check("rand_queue_empty", exp_q.size(), 0);
    end
    rand_ready = 1'b0;
    imem_ready = 1'b1;

    // Address overflow on the 2-bit instance; the 8-bit one keeps loading
    ovf_n = 0;
    ovf_chk = 1'b1;
    do_start();
    for (int i = 0; i < 5; i++) begin
      model(2'd0, 4'h0, 3'(i), 3'd0, 8'(i), lg, hl, w);
      exp_q.push_back({8'(i), w});
      send(2'd0, 4'h0, 3'(i), 3'd0, 8'(i));
    end
    n = 0;
    while ((!ovf_err || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check("t6_ovf", {ovf_err, ovf_code, ovf_busy, ovf_cnt}, {1'b1, 2'b10, 1'b0, 3'd4});
    check("t6_ovf_writes", ovf_n, 4);
    check("t6_main_loading", {busy, err, word_cnt}, {2'b10, 9'd5});

    // Asynchronous reset mid-load
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_reset", {fld_ready, imem_we, busy, done, err, err_code, word_cnt}, 0);
    check("t6_async_reset_bus", {imem_addr, imem_wdata}, 0);
    check("t6_async_reset_ovf", {ovf_err, ovf_code, ovf_cnt}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // HLT landing on the last address finishes cleanly
    ovf_n = 0;
    do_start();
    for (int i = 0; i < 3; i++) begin
      model(2'd1, 4'h0, 3'(i), 3'd1, 8'(i + 64), lg, hl, w);
      exp_q.push_back({8'(i), w});
      send(2'd1, 4'h0, 3'(i), 3'd1, 8'(i + 64));
    end
    exp_q.push_back({8'd3, 16'hC0F0});
    send(2'd3, 4'hF, 3'd0, 3'd0, 8'h00);
    wait_end();
    tick();
    check("t7_hlt_at_max", {ovf_done, ovf_err, ovf_code, ovf_cnt}, {2'b10, 2'b00, 3'd4});
    check("t7_ovf_writes", ovf_n, 4);
    check("t7_main_done", {done, word_cnt}, {1'b1, 9'd4});
    ovf_chk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
